// File: rtl/head_prune_pkg.sv
// Shared types, default geometry and width helpers for the head-pruning sequencer.
package head_prune_pkg;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_BEATS_PER_HEAD = 32;
    localparam int DEF_NUM_HEADS      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        REPORT = 2'd3
    } state_e;

    // One beat sums 32 absolute products of 2*width bits.
    function automatic int sum_width(input int width);
        return 2 * width + 5;
    endfunction

    function automatic int acc_width(input int width, input int beats);
        return sum_width(width) + $clog2(beats);
    endfunction

endpackage

// File: rtl/prune_accum.sv
// Clear/add accumulator for one head's beat sums.
// HEAD_PRUNE_SAT_EN defined: saturate at all-ones; otherwise wrap modulo 2^ACC_W.
module prune_accum #(
    parameter int SUM_W = 21,
    parameter int ACC_W = 26
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             clr,
    input  logic             add,
    input  logic [SUM_W-1:0] add_val,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
`ifdef HEAD_PRUNE_SAT_EN
    logic [ACC_W:0]   wide_s;

    assign wide_s = {1'b0, acc_q} + (ACC_W+1)'(add_val);
`endif

    // Next accumulator value: clear has priority over add.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add) begin
`ifdef HEAD_PRUNE_SAT_EN
            if (wide_s[ACC_W]) begin
                acc_d = '1;
            end else begin
                acc_d = wide_s[ACC_W-1:0];
            end
`else
            acc_d = acc_q + ACC_W'(add_val);
`endif
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/head_prune_ctrl.sv
// Head-pruning sequencer: accumulates beats per head, decides prune against a
// latched threshold and builds a per-pass mask. Optional macro: HEAD_PRUNE_SAT_EN.
module head_prune_ctrl
    import head_prune_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BEATS_PER_HEAD = DEF_BEATS_PER_HEAD,
    parameter int NUM_HEADS      = DEF_NUM_HEADS,
    parameter int SUM_W          = sum_width(WIDTH),
    parameter int ACC_W          = acc_width(WIDTH, BEATS_PER_HEAD),
    localparam int HEAD_W        = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 start,
    input  logic [ACC_W-1:0]     threshold,
    output logic                 busy,
    input  logic                 beat_valid,
    output logic                 beat_ready,
    input  logic [SUM_W-1:0]     beat_abs_sum,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [HEAD_W-1:0]    res_head,
    output logic                 res_prune,
    output logic [ACC_W-1:0]     res_sum,
    output logic [NUM_HEADS-1:0] prune_mask,
    output logic                 pass_done
);

    localparam int CNT_W = $clog2(BEATS_PER_HEAD);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS_PER_HEAD - 1);
    localparam logic [HEAD_W-1:0] LAST_HEAD = HEAD_W'(NUM_HEADS - 1);

    state_e                state_q, state_d;
    logic [ACC_W-1:0]      thr_q, thr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [HEAD_W-1:0]     head_q, head_d;
    logic [ACC_W-1:0]      res_sum_q, res_sum_d;
    logic                  res_prune_q, res_prune_d;
    logic [NUM_HEADS-1:0]  mask_q, mask_d;
    logic                  pass_done_q, pass_done_d;
    logic                  busy_q, busy_d;
    logic                  beat_ready_q, beat_ready_d;
    logic                  res_valid_q, res_valid_d;
    logic                  acc_clr_s;
    logic                  acc_add_s;
    logic [ACC_W-1:0]      acc_s;

    prune_accum #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W)
    ) u_accum (
        .clk     (clk),
        ._reset  (_reset),
        .clr     (acc_clr_s),
        .add     (acc_add_s),
        .add_val (beat_abs_sum),
        .acc     (acc_s)
    );

    // Sequencer next-state, counters, decision and mask.
    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        cnt_d       = cnt_q;
        head_d      = head_q;
        res_sum_d   = res_sum_q;
        res_prune_d = res_prune_q;
        mask_d      = mask_q;
        pass_done_d = 1'b0;
        acc_clr_s   = 1'b0;
        acc_add_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    thr_d     = threshold;
                    cnt_d     = '0;
                    head_d    = '0;
                    mask_d    = '0;
                    acc_clr_s = 1'b1;
                    state_d   = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (beat_valid && beat_ready_q) begin
                    acc_add_s = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DECIDE: begin
                res_sum_d      = acc_s;
                res_prune_d    = (acc_s <= thr_q);
                mask_d[head_q] = (acc_s <= thr_q);
                state_d        = REPORT;
            end
            REPORT: begin
                if (res_ready) begin
                    if (head_q == LAST_HEAD) begin
                        pass_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        head_d    = head_q + HEAD_W'(1);
                        cnt_d     = '0;
                        acc_clr_s = 1'b1;
                        state_d   = ACCUM;
                    end
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake outputs are registered decodes of the next state.
        busy_d       = (state_d != IDLE);
        beat_ready_d = (state_d == ACCUM);
        res_valid_d  = (state_d == REPORT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= IDLE;
            thr_q        <= '0;
            cnt_q        <= '0;
            head_q       <= '0;
            res_sum_q    <= '0;
            res_prune_q  <= 1'b0;
            mask_q       <= '0;
            pass_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            beat_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            thr_q        <= thr_d;
            cnt_q        <= cnt_d;
            head_q       <= head_d;
            res_sum_q    <= res_sum_d;
            res_prune_q  <= res_prune_d;
            mask_q       <= mask_d;
            pass_done_q  <= pass_done_d;
            busy_q       <= busy_d;
            beat_ready_q <= beat_ready_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign busy       = busy_q;
    assign beat_ready = beat_ready_q;
    assign res_valid  = res_valid_q;
    assign res_head   = head_q;
    assign res_prune  = res_prune_q;
    assign res_sum    = res_sum_q;
    assign prune_mask = mask_q;
    assign pass_done  = pass_done_q;

endmodule

// File: tb/tb_head_prune_ctrl.sv
// Randomized self-checking bench for head_prune_ctrl against a per-head sum model.
module tb_head_prune_ctrl;
    import head_prune_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int B  = DEF_BEATS_PER_HEAD;
    localparam int H  = DEF_NUM_HEADS;
    localparam int SW = sum_width(W);
    localparam int AW = acc_width(W, B);
    localparam int HW = (H > 1) ? $clog2(H) : 1;

    logic          clk = 1'b0;
    logic          _reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] threshold = '0;
    logic          busy;
    logic          beat_valid = 1'b0;
    logic          beat_ready;
    logic [SW-1:0] beat_abs_sum = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [HW-1:0] res_head;
    logic          res_prune;
    logic [AW-1:0] res_sum;
    logic [H-1:0]  prune_mask;
    logic          pass_done;

    // Narrow-accumulator instance: ACC_W == SUM_W, one head.
    logic          s_start = 1'b0;
    logic [SW-1:0] s_threshold = '0;
    logic          s_busy;
    logic          s_beat_valid = 1'b0;
    logic          s_beat_ready;
    logic [SW-1:0] s_beat_abs_sum = '0;
    logic          s_res_valid;
    logic          s_res_ready = 1'b0;
    logic [0:0]    s_res_head;
    logic          s_res_prune;
    logic [SW-1:0] s_res_sum;
    logic [0:0]    s_prune_mask;
    logic          s_pass_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [SW-1:0] beats [H][B];

    always #5 clk = ~clk;

    head_prune_ctrl dut (
        .clk(clk), ._reset(_reset), .start(start), .threshold(threshold), .busy(busy),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_abs_sum(beat_abs_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_head(res_head),
        .res_prune(res_prune), .res_sum(res_sum), .prune_mask(prune_mask),
        .pass_done(pass_done)
    );

    head_prune_ctrl #(.NUM_HEADS(1), .ACC_W(SW)) dut_narrow (
        .clk(clk), ._reset(_reset), .start(s_start), .threshold(s_threshold), .busy(s_busy),
        .beat_valid(s_beat_valid), .beat_ready(s_beat_ready), .beat_abs_sum(s_beat_abs_sum),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_head(s_res_head),
        .res_prune(s_res_prune), .res_sum(s_res_sum), .prune_mask(s_prune_mask),
        .pass_done(s_pass_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference accumulator: exact total reduced to an aw-bit result.
    function automatic logic [63:0] model_acc(input logic [63:0] total, input int aw);
        logic [63:0] lim;
        lim = (64'd1 << aw) - 64'd1;
`ifdef HEAD_PRUNE_SAT_EN
        return (total > lim) ? lim : total;
`else
        return total & lim;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_beat_ready"}, beat_ready, 0);
        check_eq({tag, "_res_valid"}, res_valid, 0);
        check_eq({tag, "_res_head"}, res_head, 0);
        check_eq({tag, "_res_prune"}, res_prune, 0);
        check_eq({tag, "_res_sum"}, res_sum, 0);
        check_eq({tag, "_prune_mask"}, prune_mask, 0);
        check_eq({tag, "_pass_done"}, pass_done, 0);
    endtask

    // Runs one pass over beats[][]; called and returns at a negedge with DUT idle.
    task automatic run_pass(input logic [AW-1:0] thr, input int vprob, input int rdelay,
                            input bit mid_start, input int abort_h, input int abort_b);
        logic [63:0] total, exp_sum;
        logic [H-1:0] exp_mask;
        logic [AW-1:0] held_sum;
        logic exp_prune;
        int b, guard, n;
        exp_mask = '0;
        @(negedge clk);
        start = 1'b1;
        threshold = thr;
        @(negedge clk);
        start = 1'b0;
        threshold = ~thr;
        check_eq("busy_after_start", busy, 1);
        check_eq("ready_after_start", beat_ready, 1);
        for (int h = 0; h < H; h++) begin
            total = 64'd0;
            for (int k = 0; k < B; k++) total += 64'(beats[h][k]);
            b = 0;
            guard = 0;
            while (b < B && guard < 4000) begin
                if (h == abort_h && b == abort_b) begin
                    beat_valid = 1'b0;
                    _reset = 1'b0;
                    #1;
                    check_reset_outputs("abort");
                    @(negedge clk);
                    _reset = 1'b1;
                    return;
                end
                beat_valid = ($urandom_range(0, 99) < vprob);
                beat_abs_sum = beats[h][b];
                start = mid_start && (b == 5);
                threshold = thr ^ AW'($urandom_range(1, 255));
                if (beat_valid && beat_ready) b++;
                @(negedge clk);
                guard++;
            end
            beat_valid = 1'b0;
            start = 1'b0;
            if (b < B) begin
                check_eq("beat_budget", b, B);
                return;
            end
            n = 0;
            while (!res_valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            check_eq("decide_latency", n, 1);
            exp_sum = model_acc(total, AW);
            exp_prune = (exp_sum <= 64'(thr));
            exp_mask[h] = exp_prune;
            check_eq("res_head", res_head, h);
            check_eq("res_sum", res_sum, exp_sum);
            check_eq("res_prune", res_prune, exp_prune);
            check_eq("mask_in_report", prune_mask, exp_mask);
            held_sum = res_sum;
            for (int d = 0; d < rdelay; d++) begin
                beat_valid = 1'b1;
                beat_abs_sum = SW'($urandom);
                @(negedge clk);
                check_eq("hold_valid", res_valid, 1);
                check_eq("hold_sum", res_sum, held_sum);
                check_eq("hold_head", res_head, h);
                check_eq("no_beat_in_report", beat_ready, 0);
            end
            beat_valid = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check_eq("valid_drops", res_valid, 0);
            if (h == H - 1) begin
                check_eq("pass_done_pulse", pass_done, 1);
                check_eq("busy_at_done", busy, 0);
                @(negedge clk);
                check_eq("pass_done_single", pass_done, 0);
            end else begin
                check_eq("next_head_ready", beat_ready, 1);
            end
        end
        repeat (3) @(negedge clk);
        check_eq("mask_persists", prune_mask, exp_mask);
    endtask

    task automatic fill_const(input int h, input logic [SW-1:0] v);
        for (int k = 0; k < B; k++) beats[h][k] = v;
    endtask

    task automatic fill_random(input int hi);
        for (int h = 0; h < H; h++)
            for (int k = 0; k < B; k++) beats[h][k] = SW'($urandom_range(0, hi));
    endtask

    initial begin
        logic [63:0] total;
        int n;
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        _reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Directed: 160 vs 220 prunes, 320 does not.
        fill_const(0, SW'(5));
        for (int h = 1; h < H; h++) fill_const(h, SW'(10));
        run_pass(AW'(220), 100, 0, 1'b0, -1, -1);
        check_eq("directed_mask", prune_mask, 4'b0001);

        // Boundary sums 220 / 221, zero, and all-max beats.
        fill_const(0, SW'(7));  beats[0][B-1] = SW'(3);
        fill_const(1, SW'(7));  beats[1][B-1] = SW'(4);
        fill_const(2, SW'(0));
        fill_const(3, {SW{1'b1}});
        run_pass(AW'(220), 70, 2, 1'b0, -1, -1);
        check_eq("boundary_mask", prune_mask, 4'b0101);

        // Random beats, random valid, held res_ready.
        for (int p = 0; p < 4; p++) begin
            fill_random(100);
            run_pass(AW'($urandom_range(1000, 2200)), 50, 5, 1'b0, -1, -1);
        end

        // Start pulsed mid-pass with a different threshold.
        fill_random(100);
        run_pass(AW'($urandom_range(1000, 2200)), 60, 1, 1'b1, -1, -1);

        // Reset after 10 beats of head 1, then an all-zero pass.
        fill_random(100);
        beats[0][0] = SW'(77);
        run_pass(AW'(1600), 80, 0, 1'b0, 1, 10);
        for (int h = 0; h < H; h++) fill_const(h, SW'(0));
        run_pass(AW'($urandom_range(0, 5000)), 100, 0, 1'b0, -1, -1);
        check_eq("zero_pass_mask", prune_mask, 4'b1111);

        // Narrow accumulator with max beats: saturate or wrap.
        @(negedge clk);
        s_start = 1'b1;
        s_threshold = SW'(0);
        @(negedge clk);
        s_start = 1'b0;
        s_beat_valid = 1'b1;
        s_beat_abs_sum = {SW{1'b1}};
        s_res_ready = 1'b1;
        n = 0;
        while (!s_res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        s_beat_valid = 1'b0;
        check_eq("narrow_valid", s_res_valid, 1);
        total = 64'(B) * ((64'd1 << SW) - 64'd1);
        check_eq("narrow_sum", s_res_sum, model_acc(total, SW));
        check_eq("narrow_prune", s_res_prune, (model_acc(total, SW) == 64'd0));
        @(negedge clk);
        s_res_ready = 1'b0;
        check_eq("narrow_done", s_pass_done, 1);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/head_prune_ctrl.md
# head_prune_ctrl

Sequencer for the head-pruning datapath. It accepts per-beat absolute sums of Q*K sub-results from the systolic array's abs/adder stage and accumulates them over a fixed number of beats per head. At the end of each head it compares the total against a threshold and reports a prune decision per head to the attention scheduler, while building a prune mask across all heads of one layer pass.

## Interface
- WIDTH, 8, operand width; products are 2*WIDTH signed
- BEATS_PER_HEAD, 32, beats accumulated per head (>=2)
- NUM_HEADS, 4, heads per pass (>=1)
- SUM_W, 2*WIDTH+5, width of one beat sum (32 absolute values of 2*WIDTH)
- ACC_W, SUM_W+$clog2(BEATS_PER_HEAD), accumulator width
- clk  in  1  clock
- _reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a pass; ignored while busy
- threshold  in  ACC_W  prune threshold; sampled on accepted start
- busy  out  1  high from accepted start until pass completes
- beat_valid  in  1  beat_abs_sum is valid
- beat_ready  out  1  controller accepts a beat
- beat_abs_sum  in  SUM_W  unsigned absolute sum of one beat
- res_valid  out  1  per-head result is valid
- res_ready  in  1  scheduler consumes the result
- res_head  out  $clog2(NUM_HEADS) (min 1)  head index of the result
- res_prune  out  1  1 = head pruned (sum <= threshold)
- res_sum  out  ACC_W  final accumulated sum of the head
- prune_mask  out  NUM_HEADS  bit h = prune decision of head h in the current/last pass
- pass_done  out  1  one-cycle pulse after the last head's result is consumed

## Operation
- States: IDLE, ACCUM, DECIDE, REPORT.
- IDLE: on start, latch threshold, clear accumulator, beat counter, head index and prune_mask -> ACCUM.
- ACCUM: beat_ready=1. On beat_valid&&beat_ready: acc += beat_abs_sum, beat_cnt++. The beat that makes beat_cnt reach BEATS_PER_HEAD -> DECIDE.
- DECIDE (one cycle): prune = (acc <= thr_q), unsigned compare; register res_sum=acc, res_prune, prune_mask[head]=prune -> REPORT.
- REPORT: res_valid=1, outputs stable until res_ready. On res_valid&&res_ready: if head==NUM_HEADS-1, pulse pass_done next cycle and -> IDLE; else head++, clear acc and beat_cnt -> ACCUM.
- start while busy: ignored, with no effect on thr_q.
- beat_valid outside ACCUM: not accepted (beat_ready=0); the beat is held by the producer.
- prune_mask persists after the pass until the next accepted start.
- Reset mid-pass: all state returns to reset values immediately; a partial head produces no result.

## Timing
- Reset values: busy=0, beat_ready=0, res_valid=0, res_head=0, res_prune=0, res_sum=0, prune_mask=0, pass_done=0; state IDLE.
- beat_ready is a registered-state decode (no combinational path from beat_valid).
- start accepted at edge k -> ACCUM at k+1 (beat_ready=1, busy=1).
- Last beat accepted at edge n -> DECIDE at n+1 -> res_valid=1 at n+2.
- res_ready may be held high: result consumed in the first REPORT cycle; next head's ACCUM begins the following cycle.
- Minimum pass length: NUM_HEADS*(BEATS_PER_HEAD+2) cycles plus 1 for start.
- pass_done is high for exactly the cycle the FSM is back in IDLE; busy=0 that cycle.

## Configuration
- HEAD_PRUNE_SAT_EN defined: accumulator saturates at 2^ACC_W-1 and never wraps.
- HEAD_PRUNE_SAT_EN undefined: accumulator wraps modulo 2^ACC_W. With the default ACC_W it cannot overflow for legal beat sums.

## Structure
- Package head_prune_pkg: state enum (IDLE/ACCUM/DECIDE/REPORT), default WIDTH, BEATS_PER_HEAD, NUM_HEADS, and a SUM_W/ACC_W width function.
- One sub-module, prune_accum: clear/add/saturate accumulator, containing the HEAD_PRUNE_SAT_EN logic. The FSM, counters and mask live in head_prune_ctrl.

## Test plan
- Defaults, threshold=220, head0 beats all 5 (sum 160), heads1..3 beats all 10 (sum 320) -> res_prune 1,0,0,0; prune_mask=4'b0001; pass_done one pulse.
- Boundary: head sum exactly 220 -> prune=1; sum 221 -> prune=0.
- beat_valid toggled randomly, res_ready held low 5 cycles -> res_valid/res_sum/res_head stable throughout; no beats accepted in REPORT; sums exact.
- start pulsed during ACCUM with a different threshold -> ignored; decisions use the first threshold.
- _reset asserted after 10 beats of head 1 -> all outputs at reset values; a new start with 32 beats of 0 -> res_sum=0, prune=1.
- Sat build, ACC_W overridden to SUM_W, beats at max -> res_sum=2^ACC_W-1; non-sat build same stimulus -> wrapped value.
